// File: rtl/wb_ram.sv
//==============================================================================
// Module      : wb_ram
// Description : Wishbone classic single-transfer slave backed by a
//               2^AW x 32-bit RAM, with a configurable number of wait states
//               between request capture and ACK.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

// Master-to-slave bundle: {CYC, STB, WE, SEL[3:0], ADR[31:0], DAT[31:0]}
`ifndef WB_M2S
`define WB_M2S logic [70:0]
`endif
// Slave-to-master bundle: {ACK, DAT[31:0]}
`ifndef WB_S2M
`define WB_S2M logic [32:0]
`endif

module wb_ram #(
   parameter int AW          = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic    i_clk,
   input  logic    i_rstn,
   input  `WB_M2S  i_m2s_wb,
   output `WB_S2M  o_s2m_wb
);

   // Out-of-range wait-state requests saturate at the counter's maximum.
   localparam int         C_WS_EFF  = (WAIT_STATES < 0 || WAIT_STATES > 7) ? 7 : WAIT_STATES;
   localparam logic [2:0] C_WS_LOAD = 3'(C_WS_EFF);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   // Bundle field breakout
   logic        w_cyc;
   logic        w_stb;
   logic        w_we;
   logic [3:0]  w_sel;
   logic [31:0] w_adr;
   logic [31:0] w_dat;

   assign w_cyc = i_m2s_wb[70];
   assign w_stb = i_m2s_wb[69];
   assign w_we  = i_m2s_wb[68];
   assign w_sel = i_m2s_wb[67:64];
   assign w_adr = i_m2s_wb[63:32];
   assign w_dat = i_m2s_wb[31:0];

   // Byte offset and bits above the word index are don't-care: addresses alias.
   logic w_unused_adr;
   assign w_unused_adr = ^{w_adr[31:AW+2], w_adr[1:0]};

   state_t          state_q, state_d;
   logic [2:0]      cnt_q,   cnt_d;
   logic [AW-1:0]   idx_q,   idx_d;
   logic            we_q,    we_d;
   logic [3:0]      sel_q,   sel_d;
   logic [31:0]     dat_q,   dat_d;
   logic            w_commit;
   logic            w_ack;

   logic [31:0]     mem_q [2**AW];

   // Next-state logic: capture in IDLE, count down in WAIT, single-cycle ACK.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      we_d     = we_q;
      sel_d    = sel_q;
      dat_d    = dat_q;
      w_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_cyc && w_stb) begin
               idx_d = w_adr[AW+1:2];
               we_d  = w_we;
               sel_d = w_sel;
               dat_d = w_dat;
               if (C_WS_EFF > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = C_WS_LOAD;
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_WAIT: begin
            if (!w_cyc) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == 3'd1) begin
               state_d = S_ACK;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_ACK: begin
            // Write lands on the edge leaving ACK unless the master aborted.
            state_d  = S_IDLE;
            w_commit = w_cyc && we_q;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Control and captured-request registers; reset clears an in-flight transfer.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         dat_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
      end
   end

   // Storage array with per-byte-lane write enables; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) begin
               mem_q[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
            end
         end
      end
   end

   // Read data is presented only while ACK is high, zero otherwise.
   assign w_ack    = (state_q == S_ACK);
   assign o_s2m_wb = {w_ack, (w_ack ? mem_q[idx_q] : 32'd0)};

endmodule

`default_nettype wire

// File: tb/tb_wb_ram.sv
//==============================================================================
// Module      : tb_wb_ram
// Description : Self-checking bench for wb_ram; four instances with different
//               wait-state settings share clock and reset.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_ram;

   localparam int NI = 4;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic [70:0] m2s [NI];
   logic [32:0] s2m [NI];

   // Effective wait states per instance (instance 3 is configured with 12).
   int          ws_exp [NI] = '{1, 3, 0, 7};

   int          n_cmp  = 0;
   int          n_fail = 0;

   // Reference memory image per instance, indexed by word.
   logic [31:0] mdl [NI][1024];

   always #5 clk = ~clk;

   wb_ram #(.AW(10), .WAIT_STATES(1))  u_ws1  (.i_clk(clk), .i_rstn(rstn), .i_m2s_wb(m2s[0]), .o_s2m_wb(s2m[0]));
   wb_ram #(.AW(10), .WAIT_STATES(3))  u_ws3  (.i_clk(clk), .i_rstn(rstn), .i_m2s_wb(m2s[1]), .o_s2m_wb(s2m[1]));
   wb_ram #(.AW(10), .WAIT_STATES(0))  u_ws0  (.i_clk(clk), .i_rstn(rstn), .i_m2s_wb(m2s[2]), .o_s2m_wb(s2m[2]));
   wb_ram #(.AW(10), .WAIT_STATES(12)) u_ws12 (.i_clk(clk), .i_rstn(rstn), .i_m2s_wb(m2s[3]), .o_s2m_wb(s2m[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] adr);
      return int'(adr[11:2]);
   endfunction

   // One complete transfer: checks latency, single-cycle ACK, read data and
   // zero data outside ACK; updates the reference image on a write.
   task automatic xfer(input int k, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] wdat,
                       output logic [31:0] rdat);
      int          n;
      logic        got;
      logic [31:0] exp_rd;
      logic [69:0] junk;
      exp_rd = mdl[k][widx(adr)];
      m2s[k] = {1'b1, 1'b1, we, sel, adr, wdat};
      @(posedge clk);
      // Everything but CYC must be ignored once the request is captured.
      #1 junk = {$urandom, $urandom, 6'($urandom)};
      m2s[k] = {1'b1, junk};
      got  = 1'b0;
      n    = 0;
      rdat = 32'd0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (s2m[k][32]) begin
            got  = 1'b1;
            rdat = s2m[k][31:0];
            check("ack_latency", 32'(n), 32'(ws_exp[k] + 1));
            if (!we) check("read_data", rdat, exp_rd);
         end else begin
            check("dat_zero_no_ack", s2m[k][31:0], 32'd0);
         end
      end
      check("ack_seen", {31'd0, got}, 32'd1);
      @(posedge clk);
      if (we && got) begin
         for (int i = 0; i < 4; i++)
            if (sel[i]) mdl[k][widx(adr)][8*i +: 8] = wdat[8*i +: 8];
      end
      #1 m2s[k] = '0;
      @(negedge clk);
      check("ack_one_cycle", {31'd0, s2m[k][32]}, 32'd0);
      check("dat_zero_after", s2m[k][31:0], 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [6:0]  pat;
      int          k;
      logic [31:0] a;

      for (int i = 0; i < NI; i++) m2s[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("reset_ack", {31'd0, s2m[i][32]}, 32'd0);
         check("reset_dat", s2m[i][31:0], 32'd0);
      end
      rstn = 1'b1;

      // Full-word write then read back, WAIT_STATES=1
      xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r);
      xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, r);
      check("rd_deadbeef", r, 32'hDEADBEEF);

      // Byte-lane merge
      xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344, r);
      xfer(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, r);
      xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, r);
      check("rd_lane_merge", r, 32'h11BB33DD);

      // SEL=0000 acknowledges but writes nothing
      xfer(0, 1'b1, 4'h0, 32'h20, 32'h00000000, r);
      xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, r);
      check("rd_sel_none", r, 32'h11BB33DD);

      // Address aliasing above the word index
      xfer(0, 1'b1, 4'hF, 32'h1004, 32'h5A5A5A5A, r);
      xfer(0, 1'b0, 4'hF, 32'h0004, 32'h0, r);
      check("rd_alias", r, 32'h5A5A5A5A);

      // Abort with CYC dropped in the second WAIT cycle, WAIT_STATES=3
      xfer(1, 1'b1, 4'hF, 32'h30, 32'h01020304, r);
      m2s[1] = {1'b1, 1'b1, 1'b1, 4'hF, 32'h30, 32'hFFFF0000};
      @(posedge clk);
      @(posedge clk);
      #1 m2s[1] = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_ack", {31'd0, s2m[1][32]}, 32'd0);
      end
      xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, r);
      check("rd_after_abort", r, 32'h01020304);

      // Back-to-back reads with STB/CYC held, WAIT_STATES=0
      xfer(2, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, r);
      pat = 7'b1010101;
      m2s[2] = {1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("b2b_ack", {31'd0, s2m[2][32]}, {31'd0, pat[6-i]});
         check("b2b_dat", s2m[2][31:0], pat[6-i] ? 32'hCAFEF00D : 32'd0);
      end
      @(posedge clk);
      #1 m2s[2] = '0;
      @(negedge clk);

      // Reset pulsed during WAIT of a write
      xfer(0, 1'b1, 4'hF, 32'h50, 32'h13579BDF, r);
      m2s[0] = {1'b1, 1'b1, 1'b1, 4'hF, 32'h50, 32'hFFFFFFFF};
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rst_wait_ack", {31'd0, s2m[0][32]}, 32'd0);
      check("rst_wait_dat", s2m[0][31:0], 32'd0);
      @(posedge clk);
      #1 m2s[0] = '0;
      @(negedge clk);
      rstn = 1'b1;
      xfer(0, 1'b0, 4'hF, 32'h50, 32'h0, r);
      check("rd_after_rst_wait", r, 32'h13579BDF);

      // Reset asserted during the ACK cycle clears ACK asynchronously
      m2s[0] = {1'b1, 1'b1, 1'b1, 4'hF, 32'h50, 32'h0BADF00D};
      @(posedge clk);
      @(posedge clk);
      #2;
      check("ack_before_rst", {31'd0, s2m[0][32]}, 32'd1);
      rstn = 1'b0;
      #1;
      check("rst_ack_ack", {31'd0, s2m[0][32]}, 32'd0);
      check("rst_ack_dat", s2m[0][31:0], 32'd0);
      @(posedge clk);
      #1 m2s[0] = '0;
      @(negedge clk);
      rstn = 1'b1;
      xfer(0, 1'b0, 4'hF, 32'h50, 32'h0, r);
      check("rd_after_rst_ack", r, 32'h13579BDF);

      // Prefill a pool of words on every instance, then random traffic
      for (int i = 0; i < NI; i++)
         for (int w = 64; w < 80; w++)
            xfer(i, 1'b1, 4'hF, 32'(w) << 2, $urandom, r);
      for (int it = 0; it < 200; it++) begin
         k = $urandom_range(0, NI - 1);
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(64, 79)) << 2)
             | 32'($urandom_range(0, 3));
         xfer(k, 1'($urandom), 4'($urandom), a, $urandom, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
